// File: rtl/m68k_bus_pkg.sv
// rtl/m68k_bus_pkg.sv - size/state encodings and strobe helper shared by the bus initiator
package m68k_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CYC1 = 3'd1,
        ST_GAP  = 3'd2,
        ST_CYC2 = 3'd3,
        ST_RESP = 3'd4
    } bus_state_e;

    // {uds, lds}: a byte uses the even lane at addr[0]=0 and the odd lane otherwise
    function automatic logic [1:0] strobe_sel(input logic [1:0] size, input logic addr0);
        logic [1:0] sel;
        if (size == SZ_BYTE) begin
            sel = addr0 ? 2'b01 : 2'b10;
        end else begin
            sel = 2'b11;
        end
        return sel;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - clear/enable cycle counter with a terminal flag for bus timeouts
module bus_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [15:0] cnt_q, cnt_d;

    // Count cycles spent waiting; clear wins so every bus cycle starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal flag fires in the LIMIT-th waiting cycle; a cycle with ack never counts
    assign term_o = en_i && (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - 16-bit uds/lds/rw/ack bus master for byte/word/long commands (optional BUS_TIMEOUT_EN watchdog)
module bus_initiator
    import m68k_bus_pkg::*;
#(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       data_write,
    input  logic [15:0]       data_read,
    output logic              uds,
    output logic              lds,
    output logic              rw,
    input  logic              ack
);

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [15:0]       dw_q, dw_d;
    logic [15:0]       wlo_q, wlo_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        sel_q, sel_d;
    logic              half_q, half_d;
    logic              err_q, err_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              in_cyc;
    logic              wd_term;

    assign in_cyc = (state_q == ST_CYC1) || (state_q == ST_CYC2);

`ifdef BUS_TIMEOUT_EN
    bus_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (!in_cyc),
        .en_i   (in_cyc && !ack),
        .term_o (wd_term)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign wd_term        = 1'b0;
`endif

    // Next state and command/bus register updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        dw_d    = dw_q;
        wlo_d   = wlo_q;
        size_d  = size_q;
        sel_d   = sel_q;
        half_d  = half_q;
        err_d   = err_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    half_d = 1'b0;
                    rbuf_d = '0;
                    if (req_size == SZ_RSVD || (req_size != SZ_BYTE && req_addr[0])) begin
                        // Rejected commands never touch the bus
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_CYC1;
                        addr_d  = req_addr;
                        rw_d    = req_rw;
                        sel_d   = strobe_sel(req_size, req_addr[0]);
                        wlo_d   = req_wdata[15:0];
                        case (req_size)
                            SZ_BYTE: dw_d = {req_wdata[7:0], req_wdata[7:0]};
                            SZ_WORD: dw_d = req_wdata[15:0];
                            default: dw_d = req_wdata[31:16];
                        endcase
                    end
                end
            end
            ST_CYC1, ST_CYC2: begin
                if (ack) begin
                    state_d = ST_GAP;
                    if (rw_q) begin
                        case (size_q)
                            SZ_BYTE: rbuf_d = {24'd0, addr_q[0] ? data_read[7:0] : data_read[15:8]};
                            SZ_WORD: rbuf_d = {16'd0, data_read};
                            default: begin
                                if (state_q == ST_CYC1) begin
                                    rbuf_d[31:16] = data_read;
                                end else begin
                                    rbuf_d[15:0] = data_read;
                                end
                            end
                        endcase
                    end
                end else if (wd_term) begin
                    state_d = ST_GAP;
                    err_d   = 1'b1;
                    rbuf_d  = '0;
                end
            end
            ST_GAP: begin
                // ack is deliberately ignored: a registered ack may still be high here
                if (size_q == SZ_LONG && !half_q && !err_q) begin
                    state_d = ST_CYC2;
                    half_d  = 1'b1;
                    addr_d  = addr_q + ADDR_W'(2);
                    dw_d    = wlo_q;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            dw_q    <= '0;
            wlo_q   <= '0;
            size_q  <= SZ_BYTE;
            sel_q   <= 2'b00;
            half_q  <= 1'b0;
            err_q   <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dw_q    <= dw_d;
            wlo_q   <= wlo_d;
            size_q  <= size_d;
            sel_q   <= sel_d;
            half_q  <= half_d;
            err_q   <= err_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Strobes are decoded from state so an asynchronous reset drops them immediately
    assign uds        = in_cyc && sel_q[1];
    assign lds        = in_cyc && sel_q[0];
    assign rw         = rw_q;
    assign addr       = addr_q;
    assign data_write = dw_q;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = ((state_q == ST_RESP) && !err_q) ? rbuf_q : 32'd0;

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - randomized self-checking bench for bus_initiator against a byte-level memory model
module tb_bus_initiator;
    import m68k_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [23:0] addr;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic        uds, lds, rw, ack;

    int n_cmp = 0;
    int n_fail = 0;

    bus_initiator #(.ADDR_W(24), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_rw(req_rw), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .addr(addr), .data_write(data_write), .data_read(data_read),
        .uds(uds), .lds(lds), .rw(rw), .ack(ack)
    );

    always #5 clk = ~clk;

    // Responder: 128-word peripheral memory, programmable ack delay and hold
    logic [15:0] rmem [0:127];
    logic [7:0]  mmem [0:255];
    int          ack_delay = 1;
    int          ack_hold = 0;
    bit          silent = 1'b0;
    int          seen = 0;
    int          hold_left = 0;
    int          viol = 0;
    int          resp_count = 0;
    logic [23:0] p_addr;
    logic [15:0] p_dw;
    logic [2:0]  p_ctl;
    logic [23:0] cy_addr[$];
    logic [1:0]  cy_strb[$];
    logic        cy_rw[$];
    logic [15:0] cy_dw[$];
    logic [23:0] ex_addr[$];
    logic [1:0]  ex_strb[$];
    logic [15:0] ex_dw[$];

    always @(negedge clk) begin
        if (reset) begin
            seen = 0;
            hold_left = 0;
            ack = 1'b0;
        end else if (uds || lds) begin
            if (seen > 0 && (addr !== p_addr || data_write !== p_dw || {uds, lds, rw} !== p_ctl))
                viol++;
            p_addr = addr;
            p_dw = data_write;
            p_ctl = {uds, lds, rw};
            seen++;
            if (!silent && seen == ack_delay + 1) begin
                ack = 1'b1;
                data_read = rmem[addr[7:1]];
                cy_addr.push_back(addr);
                cy_strb.push_back({uds, lds});
                cy_rw.push_back(rw);
                cy_dw.push_back(data_write);
                if (!rw) begin
                    if (uds) rmem[addr[7:1]][15:8] = data_write[15:8];
                    if (lds) rmem[addr[7:1]][7:0] = data_write[7:0];
                end
                hold_left = ack_hold;
            end
        end else begin
            seen = 0;
            if (hold_left > 0) begin
                hold_left--;
            end else begin
                ack = 1'b0;
                data_read = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && resp_valid) resp_count++;
    end

    // Reference: byte-addressed big-endian memory, one bus cycle per 16-bit half
    task automatic model_cmd(input logic [23:0] a, input logic r, input logic [1:0] sz,
                             input logic [31:0] wd, input int dly,
                             output logic e, output logic [31:0] rd, output int lat);
        int nb;
        int nc;
        logic [23:0] ba;
        ex_addr.delete(); ex_strb.delete(); ex_dw.delete();
        rd = 32'd0;
        e = (sz == 2'd3) || (sz != 2'd0 && a[0]);
        if (e) begin
            lat = 1;
            return;
        end
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < nb; i++) begin
            ba = a + 24'(i);
            if (r) rd = (rd << 8) | {24'd0, mmem[ba[7:0]]};
            else mmem[ba[7:0]] = 8'(wd >> (8 * (nb - 1 - i)));
        end
        nc = (nb + 1) / 2;
        for (int c = 0; c < nc; c++) begin
            ex_addr.push_back(a + 24'(2 * c));
            if (nb == 1) begin
                ex_strb.push_back(a[0] ? 2'b01 : 2'b10);
                ex_dw.push_back({wd[7:0], wd[7:0]});
            end else begin
                ex_strb.push_back(2'b11);
                ex_dw.push_back(16'(wd >> (nb == 4 && c == 0 ? 16 : 0)));
            end
        end
        lat = nc * (dly + 2) + 1;
    endtask

    task automatic do_cmd(input logic [23:0] a, input logic r, input logic [1:0] sz, input logic [31:0] wd,
                          output bit got, output int lat, output logic [31:0] rd, output logic e, output int scyc);
        int guard = 0;
        got = 0; lat = 0; rd = 0; e = 0; scyc = 0;
        cy_addr.delete(); cy_strb.delete(); cy_rw.delete(); cy_dw.delete();
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_addr = a; req_rw = r; req_size = sz; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 24'($urandom); req_wdata = $urandom;
        lat = 1;
        while (lat < 300) begin
            if (uds || lds) scyc++;
            if (resp_valid) begin
                got = 1; rd = resp_rdata; e = resp_err;
                break;
            end
            @(negedge clk);
            lat++;
        end
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_rw = 1'b1; req_size = 2'd0; req_wdata = '0;
        ack = 1'b0; data_read = '0;
        for (int w = 0; w < 128; w++) begin
            rmem[w] = 16'($urandom);
            mmem[2 * w] = rmem[w][15:8];
            mmem[2 * w + 1] = rmem[w][7:0];
        end
        #1;
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, uds, lds, rw} !== 6'b100001) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b, expected 100001", {req_ready, resp_valid, resp_err, uds, lds, rw});
        end
        n_cmp++;
        if ({addr, data_write, resp_rdata} !== 72'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h dw=%h rdata=%h, expected all zero", addr, data_write, resp_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word_write;
        bit got; int lat, sc, el; logic [31:0] rd, er; logic e, ee;
        model_cmd(24'h4, 1'b0, SZ_WORD, 32'h00A5C3, 1, ee, er, el);
        do_cmd(24'h4, 1'b0, SZ_WORD, 32'h00A5C3, got, lat, rd, e, sc);
        n_cmp++;
        if (!got || lat != 4 || e !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL word_write_resp: got=%0b lat=%0d err=%0b rdata=%h, expected 1 4 0 0", got, lat, e, rd);
        end
        n_cmp++;
        if (cy_addr.size() != 1 || cy_addr[0] !== 24'h4 || cy_strb[0] !== 2'b11 || cy_rw[0] !== 1'b0 || cy_dw[0] !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL word_write_bus: ncyc=%0d addr=%h strb=%b rw=%b dw=%h, expected 1 000004 11 0 a5c3",
                     cy_addr.size(), cy_addr[0], cy_strb[0], cy_rw[0], cy_dw[0]);
        end
    endtask

    task automatic test_long_read;
        bit got; int lat, sc; logic [31:0] rd; logic e;
        rmem[0] = 16'h1234; rmem[1] = 16'h5678;
        mmem[0] = 8'h12; mmem[1] = 8'h34; mmem[2] = 8'h56; mmem[3] = 8'h78;
        do_cmd(24'h0, 1'b1, SZ_LONG, 32'h0, got, lat, rd, e, sc);
        n_cmp++;
        if (!got || lat != 7 || e !== 1'b0 || rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL long_read_resp: got=%0b lat=%0d err=%0b rdata=%h, expected 1 7 0 12345678", got, lat, e, rd);
        end
        n_cmp++;
        if (cy_addr.size() != 2 || cy_addr[0] !== 24'h0 || cy_addr[1] !== 24'h2 || sc != 4) begin
            n_fail++;
            $display("FAIL long_read_bus: ncyc=%0d strobe_cycles=%0d, expected 2 cycles at 0/2 and 4 strobe cycles", cy_addr.size(), sc);
        end
    endtask

    task automatic test_byte_read;
        bit got; int lat, sc; logic [31:0] rd; logic e;
        rmem[2] = 16'hA57E; mmem[4] = 8'hA5; mmem[5] = 8'h7E;
        do_cmd(24'h5, 1'b1, SZ_BYTE, 32'h0, got, lat, rd, e, sc);
        n_cmp++;
        if (!got || rd !== 32'h7E || e !== 1'b0 || cy_strb.size() != 1 || cy_strb[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL byte_read: got=%0b rdata=%h err=%0b ncyc=%0d strb=%b, expected 1 0000007e 0 1 01",
                     got, rd, e, cy_strb.size(), cy_strb[0]);
        end
    endtask

    task automatic test_ack_hold;
        bit got; int lat, sc, cnt0; logic [31:0] rd; logic e;
        ack_hold = 3;
        cnt0 = resp_count;
        do_cmd(24'h8, 1'b1, SZ_WORD, 32'h0, got, lat, rd, e, sc);
        repeat (6) @(negedge clk);
        #1;
        ack_hold = 0;
        n_cmp++;
        if (!got || rd !== {16'd0, mmem[8], mmem[9]} || resp_count - cnt0 != 1 || cy_addr.size() != 1) begin
            n_fail++;
            $display("FAIL ack_hold: got=%0b rdata=%h resps=%0d ncyc=%0d, expected 1 %h 1 1",
                     got, rd, resp_count - cnt0, cy_addr.size(), {16'd0, mmem[8], mmem[9]});
        end
    endtask

    task automatic test_misalign;
        bit got; int lat, sc; logic [31:0] rd; logic e;
        do_cmd(24'h3, 1'b0, SZ_LONG, 32'hDEADBEEF, got, lat, rd, e, sc);
        n_cmp++;
        if (!got || lat != 1 || e !== 1'b1 || rd !== 32'd0 || sc != 0 || cy_addr.size() != 0) begin
            n_fail++;
            $display("FAIL misalign: got=%0b lat=%0d err=%0b rdata=%h strobe_cycles=%0d, expected 1 1 1 0 0",
                     got, lat, e, rd, sc);
        end
    endtask

    task automatic test_back_to_back;
        bit got; int lat, sc; logic [31:0] rd; logic e;
        logic ee; logic [31:0] er; int el;
        model_cmd(24'h10, 1'b0, SZ_BYTE, 32'h5A, 1, ee, er, el);
        do_cmd(24'h10, 1'b0, SZ_BYTE, 32'h5A, got, lat, rd, e, sc);
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_resp: req_ready=%b in RESP, expected 0", req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_after: req_ready=%b after RESP, expected 1", req_ready);
        end
    endtask

    task automatic test_random;
        bit got; int lat, sc, el, cnt0; logic [31:0] rd, er, wd; logic e, ee, r;
        logic [23:0] a; logic [1:0] sz;
        for (int n = 0; n < 60; n++) begin
            a = 24'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) a = 24'hFFFFFC + 24'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            ack_delay = $urandom_range(0, 3);
            cnt0 = resp_count;
            model_cmd(a, r, sz, wd, ack_delay, ee, er, el);
            do_cmd(a, r, sz, wd, got, lat, rd, e, sc);
            n_cmp++;
            if (!got || e !== ee || rd !== er || lat != el || resp_count - cnt0 != 1) begin
                n_fail++;
                $display("FAIL rand_resp %0d a=%h sz=%0d rw=%0b: got=%0b err=%0b rdata=%h lat=%0d resps=%0d, expected err=%0b rdata=%h lat=%0d resps=1",
                         n, a, sz, r, got, e, rd, lat, resp_count - cnt0, ee, er, el);
            end
            n_cmp++;
            if (cy_addr.size() != ex_addr.size()) begin
                n_fail++;
                $display("FAIL rand_ncyc %0d: %0d bus cycles, expected %0d", n, cy_addr.size(), ex_addr.size());
            end else begin
                for (int c = 0; c < ex_addr.size(); c++) begin
                    n_cmp++;
                    if (cy_addr[c] !== ex_addr[c] || cy_strb[c] !== ex_strb[c] || cy_rw[c] !== r
                        || (!r && cy_dw[c] !== ex_dw[c])) begin
                        n_fail++;
                        $display("FAIL rand_cyc %0d.%0d: addr=%h strb=%b rw=%b dw=%h, expected %h %b %b %h",
                                 n, c, cy_addr[c], cy_strb[c], cy_rw[c], cy_dw[c], ex_addr[c], ex_strb[c], r, ex_dw[c]);
                    end
                end
            end
        end
        ack_delay = 1;
    endtask

    task automatic test_timeout;
`ifdef BUS_TIMEOUT_EN
        bit got; int lat, sc; logic [31:0] rd; logic e;
        silent = 1'b1;
        do_cmd(24'h10, 1'b1, SZ_WORD, 32'h0, got, lat, rd, e, sc);
        n_cmp++;
        if (!got || sc != 8 || lat != 10 || e !== 1'b1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_word: got=%0b strobe_cycles=%0d lat=%0d err=%0b rdata=%h, expected 1 8 10 1 0", got, sc, lat, e, rd);
        end
        do_cmd(24'h20, 1'b1, SZ_LONG, 32'h0, got, lat, rd, e, sc);
        n_cmp++;
        if (!got || sc != 8 || lat != 10 || e !== 1'b1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL timeout_long: got=%0b strobe_cycles=%0d lat=%0d err=%0b rdata=%h, expected 1 8 10 1 0", got, sc, lat, e, rd);
        end
        silent = 1'b0;
`endif
    endtask

    task automatic test_reset_mid;
        int guard = 0;
        int cnt0;
        silent = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 24'h20; req_rw = 1'b1; req_size = SZ_LONG;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (!uds && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if ({uds, lds} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_cycle: strobes=%b before reset, expected 11", {uds, lds});
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({uds, lds, req_ready, resp_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rstmid_async: uds/lds/ready/valid=%b, expected 0010", {uds, lds, req_ready, resp_valid});
        end
        cnt0 = resp_count;
        @(negedge clk);
        reset = 1'b0;
        silent = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (resp_count != cnt0 || req_ready !== 1'b1 || {uds, lds} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_noresp: resps=%0d ready=%b strobes=%b, expected 0 1 00", resp_count - cnt0, req_ready, {uds, lds});
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_long_read();
        test_byte_read();
        test_ack_hold();
        test_misalign();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        n_cmp++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL bus_stability: %0d changes while strobed, expected 0", viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
